// File: rtl/mandelbrot_iter_ctrl.sv
// Mandelbrot iteration controller: sequences one pixel at a time through the
// external combinational step logic (z_(n+1) = z_n^2 + C, |z_n|^2 > 4 flag).
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   abort             synchronous abort back to IDLE, result dropped
//   in_valid/ready    C handshake (c_real_in, c_imag_in)
//   z_*, c_*          registered z_n and C, driving the step logic
//   next_z_*          z_(n+1) returned by the step logic
//   finished          divergence flag from the step logic
//   out_valid/ready   result handshake (iter_count, escaped)
//
// Optional build macro MANDEL_ITER_STATS_EN adds pixel_total[31:0], the
// number of completed result handshakes (cleared by rst_n only).
module mandelbrot_iter_ctrl #(
    parameter int Q_LEN    = 50,
    parameter int ITER_W   = 16,
    parameter int MAX_ITER = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [Q_LEN-1:0]  c_real_in,
    input  logic [Q_LEN-1:0]  c_imag_in,
    output logic [Q_LEN-1:0]  z_real,
    output logic [Q_LEN-1:0]  z_imag,
    output logic [Q_LEN-1:0]  c_real,
    output logic [Q_LEN-1:0]  c_imag,
    input  logic [Q_LEN-1:0]  next_z_real,
    input  logic [Q_LEN-1:0]  next_z_imag,
    input  logic              finished,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ITER_W-1:0] iter_count,
    output logic              escaped
`ifdef MANDEL_ITER_STATS_EN
   ,output logic [31:0]       pixel_total
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

    localparam logic [ITER_W-1:0] MAX_CNT = ITER_W'(MAX_ITER);

    state_t              state_q;
    logic [Q_LEN-1:0]    z_real_q;
    logic [Q_LEN-1:0]    z_imag_q;
    logic [Q_LEN-1:0]    c_real_q;
    logic [Q_LEN-1:0]    c_imag_q;
    logic [ITER_W-1:0]   cnt_q;
    logic [ITER_W-1:0]   cnt_d;
    logic                esc_q;
    logic                at_limit;

    // The limit test happens before the increment, so cnt_d never wraps
    // when it is actually loaded.
    assign cnt_d    = cnt_q + 1'b1;
    assign at_limit = (cnt_q == MAX_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            z_real_q <= '0;
            z_imag_q <= '0;
            c_real_q <= '0;
            c_imag_q <= '0;
            cnt_q    <= '0;
            esc_q    <= 1'b0;
        end else if (abort) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            esc_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        c_real_q <= c_real_in;
                        c_imag_q <= c_imag_in;
                        z_real_q <= '0;
                        z_imag_q <= '0;
                        cnt_q    <= '0;
                        esc_q    <= 1'b0;
                        state_q  <= ITER;
                    end
                end
                ITER: begin
                    // Escape wins over the limit: a point escaping exactly
                    // at MAX_ITER is reported as diverged.
                    if (finished) begin
                        esc_q   <= 1'b1;
                        state_q <= DONE;
                    end else if (at_limit) begin
                        esc_q   <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        z_real_q <= next_z_real;
                        z_imag_q <= next_z_imag;
                        cnt_q    <= cnt_d;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign z_real     = z_real_q;
    assign z_imag     = z_imag_q;
    assign c_real     = c_real_q;
    assign c_imag     = c_imag_q;
    assign iter_count = cnt_q;
    assign escaped    = esc_q;

`ifdef MANDEL_ITER_STATS_EN
    logic [31:0] total_q;

    // Deliberately not cleared by abort: it counts delivered results over
    // the whole session.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_q <= '0;
        end else if (out_valid && out_ready) begin
            total_q <= total_q + 32'd1;
        end
    end

    assign pixel_total = total_q;
`endif

endmodule

// File: doc/mandelbrot_iter_ctrl.md
Name: mandelbrot_iter_ctrl

Overview:
Sequential iteration engine that drives the combinational Mandelbrot step logic for one pixel at a time. It accepts a point C over a valid/ready input handshake. It then holds z and C in registers and feeds them to the step logic. Each cycle it loads next_z until the divergence flag or the iteration limit stops it, then returns the escape count over a valid/ready output handshake. It sits between the pixel-coordinate generator and the colour mapper.

Parameters:
Q_LEN, 50, width of the signed fixed-point values (Q6.44; 44 fractional bits)
ITER_W, 16, width of the iteration counter and result
MAX_ITER, 255, iteration limit; must be at least 1 and less than 2**ITER_W

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
abort  in  1  synchronous abort; returns the FSM to IDLE and drops any result
in_valid  in  1  C is valid
in_ready  out  1  engine can accept C
c_real_in  in  Q_LEN  real part of C
c_imag_in  in  Q_LEN  imaginary part of C
z_real  out  Q_LEN  registered z_n real, to step logic
z_imag  out  Q_LEN  registered z_n imaginary, to step logic
c_real  out  Q_LEN  registered C real, to step logic
c_imag  out  Q_LEN  registered C imaginary, to step logic
next_z_real  in  Q_LEN  z_(n+1) real, from step logic
next_z_imag  in  Q_LEN  z_(n+1) imaginary, from step logic
finished  in  1  |z_n|^2 > 4, from step logic (combinational from z/C)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
iter_count  out  ITER_W  number of iterations applied before escape or limit
escaped  out  1  1 = diverged, 0 = limit reached

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; z_real, z_imag, c_real, c_imag, iter_count = 0; escaped = 0; out_valid = 0. in_ready = 1 after reset is released.
- States: IDLE, ITER, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
- IDLE: on in_valid, latch c_real/c_imag from the inputs, clear z to 0, clear iter_count to 0, go to ITER. With in_valid low, remain in IDLE.
- ITER, evaluated every cycle in this priority:
  1. If finished=1: escaped <= 1, go to DONE. z and iter_count hold.
  2. Else if iter_count == MAX_ITER: escaped <= 0, go to DONE.
  3. Else: z <= next_z, iter_count <= iter_count + 1.
- Latency: a pixel escaping with count k spends k+1 cycles in ITER. A pixel that never escapes spends MAX_ITER+1 cycles in ITER. DONE is entered the cycle after the stop decision.
- DONE: iter_count and escaped are held stable while out_valid=1 and out_ready=0. On out_ready, go to IDLE; out_valid drops the next cycle. Input C is not accepted in the same cycle as DONE (no back-to-back overlap).
- abort=1 in any state: next state IDLE, out_valid=0, iter_count and escaped cleared. abort has priority over all other transitions. In IDLE, abort with in_valid high does not accept C.
- Arithmetic: the counter never wraps, because the terminal check precedes the increment. z and C values pass through unmodified; all arithmetic is done in the step logic.
- rst_n asserted mid-ITER or mid-DONE: immediate return to the reset values; the result is lost.

Optional Feature:
MANDEL_ITER_STATS_EN
- Defined: adds output pixel_total [31:0], the count of completed output handshakes (out_valid & out_ready). It wraps at 2^32, is cleared by rst_n only (not by abort), and its reset value is 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset released, idle -> in_ready=1, out_valid=0, all data outputs 0; asserting in_valid with C=1.0+0i gives state ITER the next cycle.
- C=1.0+0i, MAX_ITER=255, out_ready=1 -> z sequence 0, 1, 2, 5; finished when z=5; iter_count=3, escaped=1; 4 cycles in ITER.
- C=0+0i -> iter_count=255, escaped=0 after 256 ITER cycles. C=-2.0+0i gives the same result (z alternates -2, 2, 2 and never exceeds the bound).
- C=1.0+0i with out_ready held low for 10 cycles -> out_valid=1 with iter_count=3 held stable; release gives IDLE the next cycle; in_valid during DONE is ignored.
- abort pulsed at ITER cycle 50 with C=0 -> IDLE the next cycle, no out_valid pulse; a following C=1.0+0i returns iter_count=3.
- With MANDEL_ITER_STATS_EN defined: 3 completed pixels plus 1 aborted -> pixel_total=3; rst_n low asynchronously clears it to 0.
